// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the SRAM port controller
package sram_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        END    = 2'd3
    } state_e;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [1:0]             be;
    } sram_req_t;

    // Lanes actually used for a request; the lower-byte-only build ignores
    // the requested enables and always runs the lower lane alone.
    function automatic logic [1:0] eff_be(input logic [1:0] be);
`ifdef SRAM_BYTE_LANE_EN
        return be;
`else
        return 2'b01 | (be & 2'b00);
`endif
    endfunction

    // Expand a lane-enable pair to a 16-bit data mask.
    function automatic logic [SRAM_DATA_W-1:0] lane_mask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/sram_port_ctrl_if.sv
// rtl/sram_port_ctrl_if.sv - request/response bus between stack logic and SRAM port
interface sram_port_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

endinterface

// File: rtl/sram_port_ctrl.sv
// rtl/sram_port_ctrl.sv - single-beat SRAM cycle sequencer; SRAM_BYTE_LANE_EN enables byte lanes
module sram_port_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,   // at most SRAM_ADDR_W
    parameter int DATA_W   = SRAM_DATA_W,   // byte-lane logic assumes 16
    parameter int WAIT_CYC = 2              // strobe-active cycles, 1..15
) (
    input  logic              clk,
    input  logic              reset,
    sram_port_ctrl_if.slave   bus,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UE_N,
    output logic              SRAM_LE_N
);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    sram_req_t         req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic active;
    logic strobe_phase;
    logic dq_oe;

    // State, wait counter, latched request and captured read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state: accept in IDLE, count down ACCESS, capture read data on
    // the edge that closes the last ACCESS cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_d.we    = bus.req_we;
                    req_d.addr  = SRAM_ADDR_W'(bus.req_addr);
                    req_d.wdata = bus.req_wdata;
                    req_d.be    = eff_be(bus.req_be);
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = 4'(WAIT_CYC);
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 4'd1) begin
                    state_d = END;
                    if (!req_q.we) begin
                        rdata_d = DATA_W'(SRAM_DQ & lane_mask(req_q.be));
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin sequencing decoded from the current state; CE stays low through END
    // so write data is held inside the chip-select window.
    always_comb begin
        active       = (state_q != IDLE);
        strobe_phase = (state_q == SETUP) || (state_q == ACCESS);
        dq_oe        = active && req_q.we;
        SRAM_CE_N    = !active;
        SRAM_OE_N    = !(strobe_phase && !req_q.we);
        SRAM_WE_N    = !((state_q == ACCESS) && req_q.we);
        SRAM_UE_N    = !(active && req_q.be[1]);
        SRAM_LE_N    = !(active && req_q.be[0]);
        SRAM_ADDR    = req_q.addr[ADDR_W-1:0];
    end

    // Only a write ever drives DQ, and OE_N is high for the whole write.
    assign SRAM_DQ = dq_oe ? req_q.wdata : {16{1'bz}};

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == END) && !req_q.we;
    assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb/tb_sram_port_ctrl.sv - randomized self-checking bench for sram_port_ctrl
module tb_sram_port_ctrl;
    import sram_pkg::*;

    localparam int W = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_port_ctrl_if #(.ADDR_W(20), .DATA_W(16)) bus ();

    wire  [15:0] SRAM_DQ;
    logic [19:0] sram_addr;
    logic        ce_n, oe_n, we_n, ue_n, le_n;

    sram_port_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_ADDR (sram_addr),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .SRAM_WE_N (we_n),
        .SRAM_UE_N (ue_n),
        .SRAM_LE_N (le_n)
    );

    // Asynchronous SRAM device model: small array, lane writes while WE_N low.
    logic [15:0] dev_mem [0:31] = '{default: 16'h0000};
    logic [4:0]  dev_idx;
    logic [15:0] dev_rd;
    assign dev_idx = {sram_addr[19], sram_addr[3:0]};
    assign dev_rd  = dev_mem[dev_idx];
    assign SRAM_DQ = (!ce_n && !oe_n) ? dev_rd : {16{1'bz}};

    always @(negedge clk) begin
        if (!ce_n && !we_n) begin
            if (!le_n) dev_mem[dev_idx][7:0]  <= SRAM_DQ[7:0];
            if (!ue_n) dev_mem[dev_idx][15:8] <= SRAM_DQ[15:8];
        end
    end

    // Request-level reference: memory contents as seen by the requester.
    logic [15:0] ref_mem [logic [19:0]];
    logic [15:0] last_rd;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] lanes(input logic [1:0] be);
`ifdef SRAM_BYTE_LANE_EN
        return be;
`else
        return 2'b01 | (be & 2'b00);
`endif
    endfunction

    function automatic logic [15:0] ref_read(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    // One full request; called at a negedge with the controller idle.
    task automatic xact(input bit we, input logic [19:0] a, input logic [15:0] d,
                        input logic [1:0] be, input bit drop);
        logic [1:0]  e;
        logic [15:0] m;
        logic [15:0] exp_rd;
        int we_in, we_out, ce_lo, oe_lo, dq_ok, rv_cnt, rv_pos, lane_bad, rdy_hi, busy_lo;
        int idle_bad;
        e = lanes(be);
        m = {{8{e[1]}}, {8{e[0]}}};
        we_in = 0; we_out = 0; ce_lo = 0; oe_lo = 0; dq_ok = 0;
        rv_cnt = 0; rv_pos = -1; lane_bad = 0; rdy_hi = 0; busy_lo = 0; idle_bad = 0;

        check("ready_before", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = 16'($urandom);
        for (int n = 0; n <= W + 1; n++) begin
            @(negedge clk);
            if (!we_n) begin
                if (n >= 1 && n <= W) we_in++;
                else we_out++;
            end
            if (!ce_n) ce_lo++;
            if (!oe_n) oe_lo++;
            if (we && SRAM_DQ === d) dq_ok++;
            if (bus.rsp_valid) begin
                rv_cnt++;
                rv_pos = n;
            end
            if (ue_n !== !e[1] || le_n !== !e[0]) lane_bad++;
            if (bus.req_ready) rdy_hi++;
            if (!bus.busy) busy_lo++;
            if (drop && n == 1) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'($urandom);
                bus.req_addr  = 20'($urandom_range(0, 7));
                bus.req_be    = 2'($urandom);
            end
            if (drop && n == 2) bus.req_valid = 1'b0;
        end
        @(negedge clk);
        check("ready_after", bus.req_ready, 1);
        check("busy_after", bus.busy, 0);
        check("ce_after", ce_n, 1);

        check("we_low_access", we_in, we ? W : 0);
        check("we_low_outside", we_out, 0);
        check("ce_low_cycles", ce_lo, W + 2);
        check("oe_low_cycles", oe_lo, we ? 0 : W + 1);
        check("lane_strobes", lane_bad, 0);
        check("ready_while_busy", rdy_hi, 0);
        check("busy_gaps", busy_lo, 0);
        if (we) begin
            check("dq_drive_cycles", dq_ok, W + 2);
            check("rsp_on_write", rv_cnt, 0);
            ref_mem[a] = (ref_read(a) & ~m) | (d & m);
            check("rdata_hold", bus.rsp_rdata, last_rd);
        end else begin
            exp_rd = ref_read(a) & m;
            check("rsp_count", rv_cnt, 1);
            check("rsp_cycle", rv_pos, W + 1);
            check("rdata", bus.rsp_rdata, exp_rd);
            last_rd = exp_rd;
        end
        if (drop) begin
            repeat (3) begin
                @(negedge clk);
                if (!ce_n || !bus.req_ready) idle_bad++;
            end
            check("drop_no_extra_cycle", idle_bad, 0);
        end
    endtask

    initial begin
        logic [19:0] ra;
        last_rd       = 16'h0000;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        #1;
        check("rst_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rdata", bus.rsp_rdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_strobes", {ce_n, oe_n, we_n, ue_n, le_n}, 5'h1f);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        xact(1'b1, 20'h00005, 16'h00A5, 2'b01, 1'b0);
        xact(1'b0, 20'h00005, 16'h0000, 2'b01, 1'b0);
        xact(1'b0, 20'h00005, 16'h0000, 2'b01, 1'b1);
        xact(1'b1, 20'h80003, 16'hBEEF, 2'b11, 1'b0);
        xact(1'b0, 20'h80003, 16'h0000, 2'b10, 1'b0);
        xact(1'b0, 20'h80003, 16'h0000, 2'b00, 1'b0);
        xact(1'b1, 20'h00006, 16'h12A5, 2'b10, 1'b0);
        xact(1'b0, 20'h00006, 16'h0000, 2'b11, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = {1'($urandom), 16'h0000, 3'($urandom_range(0, 7))};
            xact(1'($urandom), ra, 16'($urandom), 2'($urandom), ($urandom_range(0, 5) == 0));
        end

        // Reset in the middle of a write strobe.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 20'h0000F;
        bus.req_wdata = 16'h5A5A;
        bus.req_be    = 2'b11;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_we_active", we_n, 0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_we", we_n, 1);
        check("mid_rst_ce", ce_n, 1);
        check("mid_rst_oe", oe_n, 1);
        check("mid_rst_ready", bus.req_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", bus.req_ready, 1);
        check("post_rst_rdata", bus.rsp_rdata, 0);
        check("post_rst_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
